// File: rtl/vga_rx.sv
// vga_rx: VGA pin-bus receiver/checker. Recovers pixel x/y/colour, measures line and
// frame timing and tracks lock. Define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT.
module vga_rx #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pins_i,
    input  logic        de_i,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [1:0]  r_o,
    output logic [1:0]  g_o,
    output logic [1:0]  b_o,
    output logic        pix_valid_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic [7:0]  err_cnt_o,
    output logic [15:0] frame_crc_o
);
    typedef enum logic [1:0] { SEARCH, MEASURE, LOCKED } state_t;

    localparam logic        SYNC_INV   = (SYNC_ACTIVE_LOW != 0);
    localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0]  H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] pins_p1_q, pins_p2_q;
    logic       de_p1_q, de_p2_q;
    logic [9:0] hcnt_q, pcnt_q, vcnt_q, acnt_q, x_q, y_q;
    logic       line_err_q, pix_valid_q, frame_start_q;
    logic [1:0] r_q, g_q, b_q;
    state_t     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       hs_edge, vs_edge, de_rise, de_fall, line_err, frame_bad;
    logic [9:0] vcnt_n, acnt_n;
    logic [5:0] pix_p1;

    // Stage-1 vs stage-2 comparison gives the sync/DE edges, sync polarity folded in
    assign hs_edge = (pins_p1_q[7] ^ SYNC_INV) & ~(pins_p2_q[7] ^ SYNC_INV);
    assign vs_edge = (pins_p1_q[3] ^ SYNC_INV) & ~(pins_p2_q[3] ^ SYNC_INV);
    assign de_rise = de_p1_q & ~de_p2_q;
    assign de_fall = ~de_p1_q & de_p2_q;
    assign pix_p1  = {pins_p1_q[0], pins_p1_q[4], pins_p1_q[1], pins_p1_q[5],
                      pins_p1_q[2], pins_p1_q[6]};

    // An hsync edge or DE fall coinciding with the vsync edge belongs to the ending frame
    assign vcnt_n    = hs_edge ? sat_inc10(vcnt_q) : vcnt_q;
    assign acnt_n    = de_fall ? sat_inc10(acnt_q) : acnt_q;
    assign line_err  = (hs_edge && (({1'b0, hcnt_q} + 11'd1) != H_TOTAL_C)) ||
                       (de_fall && (pcnt_q != H_ACTIVE_C));
    assign frame_bad = (vcnt_n != V_TOTAL_C) || (acnt_n != V_ACTIVE_C) ||
                       line_err_q || line_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            pins_p1_q     <= '0;
            pins_p2_q     <= '0;
            de_p1_q       <= 1'b0;
            de_p2_q       <= 1'b0;
            hcnt_q        <= '0;
            pcnt_q        <= '0;
            vcnt_q        <= '0;
            acnt_q        <= '0;
            line_err_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pins_p1_q     <= pins_i;
            pins_p2_q     <= pins_p1_q;
            de_p1_q       <= de_i;
            de_p2_q       <= de_p1_q;
            hcnt_q        <= hs_edge ? '0 : sat_inc10(hcnt_q);
            pcnt_q        <= de_fall ? '0 : (de_p1_q ? sat_inc10(pcnt_q) : pcnt_q);
            vcnt_q        <= vs_edge ? '0 : vcnt_n;
            acnt_q        <= vs_edge ? '0 : acnt_n;
            line_err_q    <= vs_edge ? 1'b0 : (line_err_q | line_err);
            x_q           <= de_rise ? '0 : (de_p1_q ? sat_inc10(x_q) : x_q);
            y_q           <= vs_edge ? '0 : (de_fall ? sat_inc10(y_q) : y_q);
            r_q           <= pix_p1[5:4];
            g_q           <= pix_p1[3:2];
            b_q           <= pix_p1[1:0];
            pix_valid_q   <= de_p1_q;
            frame_start_q <= vs_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            good_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            SEARCH: begin
                // Whatever was measured before the first vsync edge is a partial frame
                if (vs_edge) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (vs_edge) begin
                    if (frame_bad) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if ((good_q + 4'd1) == LOCK_C) state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_err || (vs_edge && frame_bad)) begin
                    state_d   = SEARCH;
                    good_d    = '0;
                    err_cnt_d = sat_inc8(err_cnt_q);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        locked_o = (state_q == LOCKED);
    end

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc16_6(input logic [15:0] c, input logic [5:0] d);
        logic [15:0] s;
        s = c;
        for (int i = 5; i >= 0; i--) begin
            s = {s[14:0], 1'b0} ^ ((s[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    logic [15:0] crc_q, frame_crc_q, crc_upd;

    // The pixel arriving with the vsync edge still closes out the frame being latched
    assign crc_upd = de_p1_q ? crc16_6(crc_q, pix_p1) : crc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= '0;
        end else if (vs_edge) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= crc_upd;
        end else begin
            crc_q       <= crc_upd;
        end
    end

    assign frame_crc_o = frame_crc_q;
`else
    assign frame_crc_o = '0;
`endif

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;
    assign pix_valid_o   = pix_valid_q;
    assign frame_start_o = frame_start_q;
    assign err_cnt_o     = err_cnt_q;
endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx: scaled-down VGA timing with random colours, checked every cycle
// against an event-level reference model plus fixed expectations at key points.
module tb_vga_rx;
    localparam int H_TOT = 40;
    localparam int V_TOT = 20;
    localparam int H_ACT = 24;
    localparam int V_ACT = 12;
    localparam int LOCKN = 2;
    localparam logic SAL = 1'b1;
    localparam int HS_START = 28;
    localparam int HS_END   = 33;
    localparam int VS_START = 14;
    localparam int VS_END   = 16;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] c;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pins = 8'hFF;
    logic        de = 1'b0;
    logic [9:0]  x_o, y_o;
    logic [1:0]  r_o, g_o, b_o;
    logic        pix_valid_o, frame_start_o, locked_o;
    logic [7:0]  err_cnt_o;
    logic [15:0] frame_crc_o;

    vga_rx #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
        .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst(rst), .pins_i(pins), .de_i(de),
        .x_o(x_o), .y_o(y_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .pix_valid_o(pix_valid_o), .frame_start_o(frame_start_o),
        .locked_o(locked_o), .err_cnt_o(err_cnt_o), .frame_crc_o(frame_crc_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    smp_t m_cur, m_prev;
    int t, hs_last, rise_t, y_falls, lines_seen, act_lines;
    bit frame_dirty;
    int mode;  // 0 searching, 1 measuring, 2 locked
    int good, errs;
    int crc_run, crc_frame;
    int ex_x, ex_y, ex_r, ex_g, ex_b, ex_pv, ex_fs, ex_lk, ex_err, ex_crc;

    int fs_cnt, lk_at, prev_tag;
    logic lk_prev = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic int crc_step(input int crc, input int word);
        int c;
        int fb;
        c = crc;
        for (int i = 5; i >= 0; i--) begin
            fb = ((c >> 15) ^ (word >> i)) & 1;
            c = (c << 1) & 32'h0000FFFF;
            if (fb != 0) c = c ^ 32'h00001021;
        end
        return c;
    endfunction

    function automatic int crc_of_zeros(input int n);
        int c;
        c = 32'h0000FFFF;
        for (int i = 0; i < n; i++) c = crc_step(c, 0);
        return c;
    endfunction

    task automatic model_reset();
        m_cur = {SAL, SAL, 1'b0, 6'd0};  // pins cleared to 0 by reset
        m_prev = m_cur;
        hs_last = t; rise_t = t; y_falls = 0; lines_seen = 0; act_lines = 0;
        frame_dirty = 0; mode = 0; good = 0; errs = 0;
        crc_run = 32'h0000FFFF; crc_frame = 0;
        ex_x = 0; ex_y = 0; ex_r = 0; ex_g = 0; ex_b = 0; ex_pv = 0; ex_fs = 0;
        ex_lk = 0; ex_err = 0; ex_crc = 0;
    endtask

    task automatic model_clock();
        bit hs_e, vs_e, de_r, de_f, lbad, fb;
        hs_e = m_cur.hs && !m_prev.hs;
        vs_e = m_cur.vs && !m_prev.vs;
        de_r = m_cur.de && !m_prev.de;
        de_f = !m_cur.de && m_prev.de;
        t++;
        lbad = 0;
        if (hs_e) begin
            if (t - hs_last != H_TOT) lbad = 1;
            hs_last = t;
            lines_seen++;
        end
        if (de_f) begin
            if (t - rise_t != H_ACT) lbad = 1;
            act_lines++;
        end
        if (de_r) rise_t = t;
        if (m_cur.de) ex_x = clip(t - rise_t);
        if (vs_e) y_falls = 0;
        else if (de_f) y_falls++;
        ex_y = clip(y_falls);
        if (lbad) frame_dirty = 1;
        fb = vs_e && (lines_seen != V_TOT || act_lines != V_ACT || frame_dirty);
        case (mode)
            0: if (vs_e) begin mode = 1; good = 0; end
            1: if (vs_e) begin
                if (fb) good = 0;
                else begin
                    good++;
                    if (good == LOCKN) mode = 2;
                end
            end
            default: if (lbad || fb) begin
                mode = 0; good = 0;
                if (errs < 255) errs++;
            end
        endcase
        if (m_cur.de) crc_run = crc_step(crc_run, int'(m_cur.c));
        if (vs_e) begin
            lines_seen = 0; act_lines = 0; frame_dirty = 0;
            crc_frame = crc_run; crc_run = 32'h0000FFFF;
        end
        ex_r = int'(m_cur.c[5:4]);
        ex_g = int'(m_cur.c[3:2]);
        ex_b = int'(m_cur.c[1:0]);
        ex_pv = int'(m_cur.de);
        ex_fs = int'(vs_e);
        ex_lk = (mode == 2) ? 1 : 0;
        ex_err = errs;
`ifdef VGA_RX_CRC_EN
        ex_crc = crc_frame;
`else
        ex_crc = 0;
`endif
    endtask

    task automatic compare_all();
        chk("x", int'(x_o), ex_x);
        chk("y", int'(y_o), ex_y);
        chk("r", int'(r_o), ex_r);
        chk("g", int'(g_o), ex_g);
        chk("b", int'(b_o), ex_b);
        chk("pix_valid", int'(pix_valid_o), ex_pv);
        chk("frame_start", int'(frame_start_o), ex_fs);
        chk("locked", int'(locked_o), ex_lk);
        chk("err_cnt", int'(err_cnt_o), ex_err);
        chk("frame_crc", int'(frame_crc_o), ex_crc);
    endtask

    task automatic step(input smp_t s, input logic r, input int tag);
        @(negedge clk);
        pins = {s.hs ^ SAL, s.c[0], s.c[2], s.c[4], s.vs ^ SAL, s.c[1], s.c[3], s.c[5]};
        de = s.de;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            model_clock();
            m_prev = m_cur;
            m_cur = s;
        end
        compare_all();
        if (r) begin
            chk("rst_x", int'(x_o), 0);
            chk("rst_y", int'(y_o), 0);
            chk("rst_rgb", int'({r_o, g_o, b_o}), 0);
            chk("rst_pv_fs_lk", int'({pix_valid_o, frame_start_o, locked_o}), 0);
            chk("rst_err", int'(err_cnt_o), 0);
            chk("rst_crc", int'(frame_crc_o), 0);
            prev_tag = 0;
        end else begin
            if (prev_tag == 1) begin
                chk("first_px_x", int'(x_o), 0);
                chk("first_px_y", int'(y_o), 0);
                chk("first_px_rgb", int'({r_o, g_o, b_o}), 6'b110000);
                chk("first_px_pv", int'(pix_valid_o), 1);
            end else if (prev_tag == 2) begin
                chk("last_px_x", int'(x_o), 23);
                chk("last_px_y", int'(y_o), 11);
                chk("last_px_pv", int'(pix_valid_o), 1);
            end
            prev_tag = tag;
        end
        if (frame_start_o) fs_cnt++;
        if (locked_o && !lk_prev) lk_at = fs_cnt;
        lk_prev = locked_o;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step({1'b0, 1'b0, 1'b0, 6'd0}, r, 0);
    endtask

    task automatic frame(input int nlines, input int stretch_line, input bit jitter,
                         input bit black, input bit mark, input int rst_line);
        int len;
        int j;
        smp_t s;
        int tag;
        for (int v = 0; v < nlines; v++) begin
            len = H_TOT + ((v == stretch_line) ? 1 : 0);
            if (jitter) begin
                j = int'($urandom_range(0, 24));
                if (j == 0) len = len + 1;
                else if (j == 1) len = len - 1;
            end
            for (int h = 0; h < len; h++) begin
                s.de = (v < V_ACT) && (h < H_ACT);
                s.hs = (h >= HS_START) && (h < HS_END);
                s.vs = (v >= VS_START) && (v < VS_END);
                s.c = black ? 6'd0 : 6'($urandom);
                tag = 0;
                if (mark && v == 0 && h == 0) begin
                    s.c = 6'b110000;
                    tag = 1;
                end
                if (mark && v == V_ACT - 1 && h == H_ACT - 1) tag = 2;
                step(s, (v == rst_line) && (h == 10), tag);
            end
        end
    endtask

    initial begin
        t = 0;
        prev_tag = 0;
        model_reset();

        // reset, then nominal timing: lock on the third vsync edge
        idle(3, 1'b1);
        idle(5, 1'b0);
        fs_cnt = 0; lk_at = -1;
        for (int f = 0; f < 4; f++) frame(V_TOT, -1, 0, 0, 0, -1);
        chk("p1_frame_starts", fs_cnt, 4);
        chk("p1_lock_edge", lk_at, 3);
        chk("p1_err_cnt", int'(err_cnt_o), 0);
        chk("p1_locked", int'(locked_o), 1);

        // locked: first and last active pixel positions
        frame(V_TOT, -1, 0, 0, 1, -1);
        chk("p2_locked", int'(locked_o), 1);

        // one line stretched by a clock drops lock, relock three edges later
        fs_cnt = 0; lk_at = -1;
        frame(V_TOT, 5, 0, 0, 0, -1);
        chk("p3_err_cnt", int'(err_cnt_o), 1);
        chk("p3_unlocked", int'(locked_o), 0);
        for (int f = 0; f < 3; f++) frame(V_TOT, -1, 0, 0, 0, -1);
        chk("p3_relock_edge", lk_at, 3);
        chk("p3_relocked", int'(locked_o), 1);

        // mid-frame reset, then a short frame while measuring
        fs_cnt = 0; lk_at = -1;
        frame(V_TOT, -1, 0, 0, 0, 3);
        frame(V_TOT - 1, -1, 0, 0, 0, -1);
        frame(V_TOT, -1, 0, 0, 0, -1);
        frame(V_TOT, -1, 0, 0, 0, -1);
        chk("p4_not_yet", int'(locked_o), 0);
        frame(V_TOT, -1, 0, 0, 0, -1);
        chk("p4_lock_edge", lk_at, 5);
        chk("p4_locked", int'(locked_o), 1);
        chk("p4_err_cnt", int'(err_cnt_o), 0);

        // all-black frames
        frame(V_TOT, -1, 0, 1, 0, -1);
        frame(V_TOT, -1, 0, 1, 0, -1);
`ifdef VGA_RX_CRC_EN
        chk("black_crc", int'(frame_crc_o), crc_of_zeros(H_ACT * V_ACT));
`else
        chk("black_crc", int'(frame_crc_o), 0);
`endif

        // random line-length jitter
        for (int f = 0; f < 6; f++) frame(V_TOT, -1, 1, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Pin-level VGA receiver/checker: the receiving end of the 640x480 VGA interface that the pong top drives.
- Samples the 8-bit RGB222/sync pin bus plus DE.
- Reconstructs pixel coordinates and colour, and measures line and frame timing against nominal values.
- Reports lock status, timing errors and a per-frame start pulse. Used in bench and self-test (loopback) builds.

Parameters:
- H_TOTAL, 800, expected clocks between successive hsync assertion edges
- V_TOTAL, 525, expected lines between successive vsync assertion edges
- H_ACTIVE, 640, expected DE-high clocks per active line
- V_ACTIVE, 480, expected active lines per frame
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted when pin low
- LOCK_FRAMES, 2, consecutive clean frames required to declare lock (1..15)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- pins  in  8  {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}
- de  in  1  display enable
- x  out  10  pixel column within line
- y  out  10  active line index within frame
- r, g, b  out  2 each  pixel colour
- pix_valid  out  1  x/y/r/g/b valid this cycle
- frame_start  out  1  one-cycle pulse on vsync assertion edge
- locked  out  1  timing lock achieved
- err_cnt  out  8  saturating count of lock losses
- frame_crc  out  16  CRC of previous frame (optional feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset: every output is 0. FSM goes to SEARCH; all counters and flags are 0.
- Stage 1 registers pins and de. Edge detection compares stage 1 with a stage-2 copy.
- Sync assertion edges use the polarity set by SYNC_ACTIVE_LOW.
- Pixel outputs are registered. Latency from pins to r/g/b/pix_valid is 2 clocks.
- pix_valid = delayed de, independent of lock.
- x: 0 on the first DE-high clock of a line, then +1 per DE-high clock; saturates at 1023.
- y: 0 after a vsync assertion edge; +1 on each DE falling edge; saturates at 1023.
- hcnt counts clocks since the last hsync assertion edge. On the next edge, a line mismatch is flagged if hcnt+1 != H_TOTAL. hcnt saturates at 1023; a saturated count is a mismatch.
- pcnt counts DE-high clocks in a line. On the DE falling edge, a line mismatch is flagged if pcnt != H_ACTIVE.
- vcnt counts hsync assertion edges since the last vsync edge. An hsync edge in the same cycle as the vsync edge is counted first.
- acnt counts DE falling edges.
- At a vsync edge, a frame mismatch is flagged if vcnt != V_TOTAL, if acnt != V_ACTIVE, or if any line mismatch occurred in the frame. The sticky line-mismatch flag, vcnt and acnt then clear.
- frame_start is asserted the cycle after the vsync edge, together with the FSM update.
- FSM, SEARCH: on the first vsync edge, go to MEASURE with good=0. Partial-frame results are discarded.
- FSM, MEASURE: at each vsync edge, a clean frame does good+1 and a mismatched frame sets good=0. When good reaches LOCK_FRAMES, go to LOCKED and assert locked.
- FSM, LOCKED: any line or frame mismatch goes to SEARCH immediately. locked deasserts the next cycle. err_cnt +1, saturating at 255.
- Mid-operation rst: everything returns to reset values the next cycle. Lock must be re-acquired from SEARCH.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- When defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) runs over the 6-bit pixel {r,g,b} of every pix_valid cycle, MSB-first, 6 bits per clock. It is latched into frame_crc at each vsync edge, then re-initialised. frame_crc is 0 after reset.
- When undefined: no CRC logic; frame_crc is tied to 0.

Test Plan:
- Reset, then nominal 640x480 timing for 4 frames, LOCK_FRAMES=2 -> locked=1 at the 3rd vsync edge (SEARCH edge + 2 clean frames); err_cnt=0; frame_start pulses once per frame.
- Locked, first active pixel driven pins r=2'b11,g=0,b=0 -> 2 clocks later x=0, y=0, r=3, pix_valid=1; last pixel of line 479 -> x=639, y=479.
- Locked, one line stretched to 801 clocks -> locked=0 next cycle, err_cnt=1. Relock after 3 further frames.
- Frame of 524 lines during MEASURE -> good resets; locked only after 2 subsequent clean frames.
- rst pulsed mid-frame while locked -> all outputs 0 next cycle; locked=0 until re-acquired.
- VGA_RX_CRC_EN: all-black frame (6'b0 pixels) -> frame_crc equals the reference CRC of 307200 zero 6-bit words. Without the macro -> frame_crc=0.
